// File: rtl/harmonica_pred_pkg.sv
// Shared widths and the queued-write entry format for the predicate writeback path.
package harmonica_pred_pkg;

    localparam int PRED_LANES = 8;
    localparam int PRED_WARPS = 8;
    localparam int PRED_REGS  = 32;

    typedef logic [$clog2(PRED_WARPS)-1:0] pred_warp_t;
    typedef logic [$clog2(PRED_REGS)-1:0]  pred_addr_t;
    typedef logic [PRED_LANES-1:0]         pred_lane_t;

    typedef struct packed {
        pred_warp_t warp;
        pred_addr_t addr;
        pred_lane_t mask;
        pred_lane_t data;
    } pred_wb_entry_t;

endpackage

// File: rtl/predicate_writeback_queue.sv
// Coalescing FIFO of lane-masked predicate writes feeding the single write port
// of the predicate register block, with a pending-write hazard query.
module predicate_writeback_queue
    import harmonica_pred_pkg::*;
#(
    parameter int LANES     = PRED_LANES,
    parameter int WARPS     = PRED_WARPS,
    parameter int NUM_PREGS = PRED_REGS,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(WARPS)-1:0]     in_warp,
    input  logic [$clog2(NUM_PREGS)-1:0] in_addr,
    input  logic [LANES-1:0]             in_mask,
    input  logic [LANES-1:0]             in_data,
    output logic                         wr_req,
    input  logic                         wr_grant,
    output logic [LANES-1:0]             write_en,
    output logic [$clog2(NUM_PREGS)-1:0] waddr,
    output logic [LANES-1:0]             wdata,
    output logic [$clog2(WARPS)-1:0]     warp_selector,
    input  logic [$clog2(WARPS)-1:0]     chk_warp,
    input  logic [$clog2(NUM_PREGS)-1:0] chk_addr,
    output logic                         chk_pending,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);

    pred_wb_entry_t mem [DEPTH];
    pred_wb_entry_t hd, tl;
    logic [PW-1:0]  head, tail, tail_last, off;
    logic [PW:0]    cnt;
    logic           active, accept, pop, push, coalesce;

    assign tail_last = tail - 1'b1;
    assign hd        = mem[head];
    assign tl        = mem[tail_last];
    assign count     = cnt;

    always_comb begin
        active   = !rst;
        wr_req   = active && (cnt != '0);
        in_ready = active && (cnt < (PW+1)'(DEPTH));
        accept   = in_valid && in_ready;
        pop      = wr_grant && wr_req;
        write_en = pop ? hd.mask : '0;
        // The tail is only being popped when it is also the head (single entry).
        coalesce = accept && (in_mask != '0) && (cnt != '0)
                   && (tl.warp == in_warp) && (tl.addr == in_addr)
                   && !(pop && (cnt == (PW+1)'(1)));
        push     = accept && (in_mask != '0) && !coalesce;
        waddr         = active ? hd.addr : '0;
        wdata         = active ? hd.data : '0;
        warp_selector = active ? hd.warp : '0;
    end

    always_comb begin
        chk_pending = 1'b0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (active && ({1'b0, off} < cnt) && (mem[i].warp == chk_warp)
                && (mem[i].addr == chk_addr))
                chk_pending = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) head <= head + 1'b1;
            if (push) begin
                mem[tail] <= '{warp: in_warp, addr: in_addr, mask: in_mask, data: in_data};
                tail      <= tail + 1'b1;
            end
            // Newer result wins on overlapping lanes.
            if (coalesce) begin
                mem[tail_last].mask <= tl.mask | in_mask;
                mem[tail_last].data <= (tl.data & ~in_mask) | (in_data & in_mask);
            end
            cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_predicate_writeback_queue.sv
// Directed bench for the predicate writeback queue, with a small predicate memory model.
module tb_predicate_writeback_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [2:0] in_warp;
    logic [4:0] in_addr;
    logic [7:0] in_mask, in_data;
    logic       wr_req, wr_grant;
    logic [7:0] write_en, wdata;
    logic [4:0] waddr;
    logic [2:0] warp_selector;
    logic [2:0] chk_warp;
    logic [4:0] chk_addr;
    logic       chk_pending;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;
    logic [7:0] pmem [8][32];

    predicate_writeback_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_warp(in_warp), .in_addr(in_addr), .in_mask(in_mask), .in_data(in_data),
        .wr_req(wr_req), .wr_grant(wr_grant), .write_en(write_en), .waddr(waddr),
        .wdata(wdata), .warp_selector(warp_selector), .chk_warp(chk_warp),
        .chk_addr(chk_addr), .chk_pending(chk_pending), .count(count)
    );

    always #5 clk = ~clk;

    // Stand-in for the predicate register block: per-lane masked write.
    always @(posedge clk) begin
        for (int l = 0; l < 8; l++)
            if (write_en[l]) pmem[warp_selector][waddr][l] <= wdata[l];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic offer(input logic [2:0] w, input logic [4:0] a,
                         input logic [7:0] m, input logic [7:0] d);
        in_valid = 1'b1; in_warp = w; in_addr = a; in_mask = m; in_data = d;
    endtask

    // Offer and wait (bounded) until the queue takes it.
    task automatic push(input logic [2:0] w, input logic [4:0] a,
                        input logic [7:0] m, input logic [7:0] d);
        bit done = 0;
        offer(w, a, m, d);
        for (int t = 0; t < 20 && !done; t++) begin
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    initial begin
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 32; a++) pmem[w][a] = 8'h00;
        rst = 1'b1; in_valid = 0; in_warp = 0; in_addr = 0; in_mask = 0; in_data = 0;
        wr_grant = 1'b1; chk_warp = 0; chk_addr = 0;
        step(); step();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_chk_pending", chk_pending, 0);
        chk("rst_head", {warp_selector, waddr, wdata}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        // Single write, no bypass
        offer(3'd2, 5'd5, 8'hFF, 8'hA5);
        #1;
        chk("no_bypass", write_en, 8'h00);
        step();
        in_valid = 1'b0;
        #1;
        chk("single_we", write_en, 8'hFF);
        chk("single_addr", waddr, 5'h05);
        chk("single_data", wdata, 8'hA5);
        chk("single_warp", warp_selector, 3'd2);
        step();
        chk("single_empty_cnt", count, 0);
        chk("single_empty_req", wr_req, 0);

        // Fill and backpressure
        wr_grant = 1'b0;
        for (int k = 0; k < 4; k++) push(3'(k), 5'(k + 1), 8'(1 << k), 8'(8'h10 + k));
        chk("full_count", count, 4);
        chk("full_ready", in_ready, 0);
        offer(3'd5, 5'd9, 8'hFF, 8'hFF);
        step();
        in_valid = 1'b0;
        #1;
        chk("full_reject", count, 4);
        wr_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fifo_we", write_en, 8'(1 << k));
            chk("fifo_addr", waddr, 5'(k + 1));
            chk("fifo_data", wdata, 8'(8'h10 + k));
            step();
            if (k == 0) chk("ready_after_pop", in_ready, 1);
        end
        chk("fifo_drained", count, 0);

        // Coalesce
        wr_grant = 1'b0;
        push(3'd1, 5'd3, 8'h0F, 8'h05);
        push(3'd1, 5'd3, 8'h3C, 8'h28);
        chk("coal_count", count, 1);
        wr_grant = 1'b1;
        #1;
        chk("coal_we", write_en, 8'h3F);
        chk("coal_data", wdata, 8'h29);
        step();
        wr_grant = 1'b0;

        // Hazard flag, including same-cycle arrival exclusion
        offer(3'd7, 5'h1F, 8'h01, 8'h01);
        chk_warp = 3'd7; chk_addr = 5'h1F;
        #1;
        chk("haz_same_cycle", chk_pending, 0);
        step();
        in_valid = 1'b0;
        #1;
        chk("haz_hit", chk_pending, 1);
        chk_addr = 5'h1E; #1;
        chk("haz_addr_miss", chk_pending, 0);
        chk_warp = 3'd6; chk_addr = 5'h1F; #1;
        chk("haz_warp_miss", chk_pending, 0);
        chk_warp = 3'd7;
        wr_grant = 1'b1;
        step();
        chk("haz_cleared", chk_pending, 0);
        wr_grant = 1'b0;

        // Zero mask is discarded
        offer(3'd4, 5'd4, 8'h00, 8'hFF);
        step();
        in_valid = 1'b0;
        #1;
        chk("zero_mask_cnt", count, 0);
        chk("zero_mask_req", wr_req, 0);

        // Same warp/addr while the lone entry pops: new entry, not merged
        push(3'd3, 5'd4, 8'h0F, 8'hFF);
        chk("pop_push_cnt1", count, 1);
        wr_grant = 1'b1;
        offer(3'd3, 5'd4, 8'hF0, 8'h00);
        #1;
        chk("pop_push_we0", write_en, 8'h0F);
        step();
        in_valid = 1'b0;
        #1;
        chk("pop_push_cnt", count, 1);
        chk("pop_push_we1", write_en, 8'hF0);
        chk("pop_push_data", wdata, 8'h00);
        step();
        chk("pop_push_empty", count, 0);

        // Reset with entries queued
        wr_grant = 1'b0;
        for (int k = 0; k < 3; k++) push(3'd0, 5'(k + 10), 8'hFF, 8'h00);
        chk("pre_rst_count", count, 3);
        rst = 1'b1; wr_grant = 1'b1;
        #1;
        chk("rst_mid_we", write_en, 0);
        chk("rst_mid_ready", in_ready, 0);
        step();
        chk("rst_mid_count", count, 0);
        chk("rst_mid_we_after", write_en, 0);
        rst = 1'b0;
        step();
        chk("rst_mid_req", wr_req, 0);

        // End to end: lower lanes then upper lanes for every warp/register
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 32; a++) begin
                push(3'(w), 5'(a), 8'h55, 8'(w * 32 + a));
                push(3'(w), 5'(a), 8'hAA, ~8'(w * 32 + a));
            end
        for (int t = 0; t < 20 && count != 0; t++) step();
        chk("e2e_drained", count, 0);
        step();
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 32; a++) begin
                logic [7:0] d, e;
                d = 8'(w * 32 + a);
                e = (d & 8'h55) | (~d & 8'hAA);
                chk("e2e_readback", pmem[w][a], e);
            end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
